// File: rtl/if_fetch_pkg.sv
// Shared constants and fetch-state encoding for the instruction fetch stage.
package if_fetch_pkg;

    localparam logic RST_ENABLE = 1'b1;
    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    typedef enum logic [2:0] {
        IF_S_B0,
        IF_S_B1,
        IF_S_B2,
        IF_S_B3,
        IF_S_DONE
    } fetch_state_e;

    // Byte offset from pc that a fetch state is reading; S_DONE reads nothing.
    function automatic logic [1:0] byteLane(input fetch_state_e s);
        case (s)
            IF_S_B1: return 2'd1;
            IF_S_B2: return 2'd2;
            IF_S_B3: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/if_fetch_icache.sv
// Direct-mapped word cache for the fetch stage, used only when IFETCH_ICACHE_EN is defined.
// Only word-aligned PCs can hit or fill; instruction memory is read-only so no invalidation.
module ifetch_icache
    import if_fetch_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_ADDR_W-1:0] lookup_pc_i,
    output logic                   hit_o,
    output logic [INST_W-1:0]      line_o,
    input  logic                   fill_en_i,
    input  logic [INST_ADDR_W-1:0] fill_pc_i,
    input  logic [INST_W-1:0]      fill_data_i
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = INST_ADDR_W - IDX_W - 2;

    logic [INST_W-1:0] data_q [LINES];
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINES-1:0]  valid_q;

    logic [IDX_W-1:0] lookupIdx;
    logic [IDX_W-1:0] fillIdx;
    logic [TAG_W-1:0] lookupTag;
    logic [TAG_W-1:0] fillTag;
    logic             fillWrite;

    assign lookupIdx = lookup_pc_i[IDX_W+1:2];
    assign lookupTag = lookup_pc_i[INST_ADDR_W-1:IDX_W+2];
    assign fillIdx   = fill_pc_i[IDX_W+1:2];
    assign fillTag   = fill_pc_i[INST_ADDR_W-1:IDX_W+2];

    assign hit_o = valid_q[lookupIdx] && (tag_q[lookupIdx] == lookupTag)
                   && (lookup_pc_i[1:0] == 2'b00);
    assign line_o    = data_q[lookupIdx];
    assign fillWrite = fill_en_i && (fill_pc_i[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            valid_q <= '0;
        end else if (fillWrite) begin
            valid_q[fillIdx] <= 1'b1;
        end
    end

    // Payload arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fillWrite) begin
            data_q[fillIdx] <= fill_data_i;
            tag_q[fillIdx]  <= fillTag;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: assembles each 32-bit instruction from four byte reads and
// presents it to IF/ID. Defining IFETCH_ICACHE_EN adds a direct-mapped word cache.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ICACHE_LINES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_i,
    output logic                   mem_req_o,
    output logic [INST_ADDR_W-1:0] mem_addr_o,
    input  logic                   mem_gnt_i,
    input  logic [7:0]             mem_data_i,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0]      if_inst,
    output logic                   stallreq_o
);

    if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_badLines
        $error("if_fetch: ICACHE_LINES must be a power of two and at least 2");
    end

    fetch_state_e           state_q, state_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0]      instBuf_q, instBuf_d;

    logic [1:0]             lane;
    logic [INST_ADDR_W-1:0] fetchAddr;
    logic                   inFetch;
    logic                   cacheHit;
    logic [INST_W-1:0]      cacheLine;
    logic                   unusedStall;

    assign lane        = byteLane(state_q);
    assign fetchAddr   = pc_q + {30'b0, lane};
    assign inFetch     = (state_q != IF_S_DONE);
    assign unusedStall = ^stall[5:1];

`ifdef IFETCH_ICACHE_EN
    logic cacheHitRaw;
    logic cacheFill;

    // The last byte comes straight off the bus; bytes 0..2 are already buffered.
    assign cacheFill = (rst != RST_ENABLE) && !branch_flag_i
                       && (state_q == IF_S_B3) && mem_gnt_i;
    assign cacheHit  = cacheHitRaw && (state_q == IF_S_B0);

    ifetch_icache #(
        .LINES(ICACHE_LINES)
    ) u_icache (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc_i (pc_q),
        .hit_o       (cacheHitRaw),
        .line_o      (cacheLine),
        .fill_en_i   (cacheFill),
        .fill_pc_i   (pc_q),
        .fill_data_i ({mem_data_i, instBuf_q[23:0]})
    );
`else
    assign cacheHit  = 1'b0;
    assign cacheLine = ZERO_WORD;
`endif

    // A redirect overrides everything, including a grant or cache hit in the same cycle.
    always_comb begin
        pc_d      = pc_q;
        state_d   = state_q;
        instBuf_d = instBuf_q;
        if (branch_flag_i) begin
            pc_d      = branch_target_i;
            state_d   = IF_S_B0;
            instBuf_d = ZERO_WORD;
        end else if (cacheHit) begin
            instBuf_d = cacheLine;
            state_d   = IF_S_DONE;
        end else if (state_q == IF_S_DONE) begin
            case (stall[0])
                NO_STOP: begin
                    pc_d    = pc_q + 32'd4;
                    state_d = IF_S_B0;
                end
                STOP: begin
                end
            endcase
        end else if (mem_gnt_i) begin
            instBuf_d[{lane, 3'b000} +: 8] = mem_data_i;
            case (state_q)
                IF_S_B0: state_d = IF_S_B1;
                IF_S_B1: state_d = IF_S_B2;
                IF_S_B2: state_d = IF_S_B3;
                default: state_d = IF_S_DONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            pc_q      <= '0;
            state_q   <= IF_S_B0;
            instBuf_q <= ZERO_WORD;
        end else begin
            pc_q      <= pc_d;
            state_q   <= state_d;
            instBuf_q <= instBuf_d;
        end
    end

    // Outputs are forced quiet during reset and the instruction is squashed on redirect.
    always_comb begin
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
        if_pc      = '0;
        if_inst    = ZERO_WORD;
        stallreq_o = 1'b0;
        if (rst != RST_ENABLE) begin
            if_pc      = pc_q;
            stallreq_o = inFetch && !branch_flag_i;
            if (inFetch) begin
                mem_req_o  = !cacheHit;
                mem_addr_o = fetchAddr;
            end else if (!branch_flag_i) begin
                if_inst = instBuf_q;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by randomized traffic,
// all compared against a byte-count model of the fetch stage and a read-only memory image.
`timescale 1ns/1ps
module tb_if_fetch;

    localparam int LINES = 16;
    localparam int IW    = $clog2(LINES);

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic [7:0]  mem_data_i;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_o;

    logic [7:0]  memTbl [1024];
    logic [7:0]  noise;

    int checks = 0;
    int errors = 0;

    // Model: current pc, bytes collected so far (4 = instruction ready), cache contents.
    logic [31:0] mPc = '0;
    int          mN  = 0;
    bit          cValid [LINES];
    logic [31:0] cTag   [LINES];

    always #5 clk = ~clk;

    if_fetch #(
        .ICACHE_LINES(LINES)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_data_i      (mem_data_i),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .stallreq_o      (stallreq_o)
    );

    function automatic logic [7:0] memByte(input logic [31:0] a);
        return memTbl[a[9:0]];
    endfunction

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {memByte(a + 32'd3), memByte(a + 32'd2), memByte(a + 32'd1), memByte(a)};
    endfunction

    // Data is only trustworthy while granted; otherwise the bus carries garbage.
    assign mem_data_i = memByte(mem_addr_o) ^ (mem_gnt_i ? 8'h00 : noise);

    function automatic bit modelHit();
`ifdef IFETCH_ICACHE_EN
        return (mN == 0) && (mPc[1:0] == 2'b00) && cValid[mPc[IW+1:2]]
               && (cTag[mPc[IW+1:2]] == (mPc >> (IW + 2)));
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit expReq();
        return (mN < 4) && !modelHit();
    endfunction

    function automatic logic [31:0] expInst();
        return ((mN == 4) && !branch_flag_i) ? memWord(mPc) : 32'h0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mPc <= '0;
            mN  <= 0;
            for (int i = 0; i < LINES; i++) cValid[i] <= 1'b0;
        end else if (branch_flag_i) begin
            mPc <= branch_target_i;
            mN  <= 0;
        end else if (mN < 4) begin
            if (modelHit()) begin
                mN <= 4;
            end else if (mem_gnt_i) begin
                mN <= mN + 1;
                if (mN == 3 && mPc[1:0] == 2'b00) begin
                    cValid[mPc[IW+1:2]] <= 1'b1;
                    cTag[mPc[IW+1:2]]   <= mPc >> (IW + 2);
                end
            end
        end else if (!stall[0]) begin
            mPc <= mPc + 32'd4;
            mN  <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input logic [5:0] st, input bit bf,
                                 input logic [31:0] bt, input bit g);
        @(posedge clk);
        #1;
        rst             = r;
        stall           = st;
        branch_flag_i   = bf;
        branch_target_i = bt;
        mem_gnt_i       = g;
        noise           = 8'($urandom_range(1, 255));
        @(negedge clk);
    endtask

    task automatic step(input bit g);
        applyStimulus(1'b0, 6'b0, 1'b0, 32'h0, g);
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_mem_req", 32'(mem_req_o), 32'h0);
            checkOutput("rst_mem_addr", mem_addr_o, 32'h0);
            checkOutput("rst_if_pc", if_pc, 32'h0);
            checkOutput("rst_if_inst", if_inst, 32'h0);
            checkOutput("rst_stallreq", 32'(stallreq_o), 32'h0);
        end else begin
            checkOutput("mem_req", 32'(mem_req_o), 32'(expReq()));
            if (expReq()) checkOutput("mem_addr", mem_addr_o, mPc + 32'(mN));
            checkOutput("if_pc", if_pc, mPc);
            checkOutput("if_inst", if_inst, expInst());
            checkOutput("stallreq", 32'(stallreq_o), 32'((mN < 4) && !branch_flag_i));
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [5:0]  st;
        logic [31:0] tgt;
        for (int i = 0; i < 1024; i++) memTbl[i] = 8'($urandom);
        memTbl[0] = 8'h13;
        memTbl[1] = 8'h00;
        memTbl[2] = 8'h50;
        memTbl[3] = 8'h00;
        rst = 1'b1; stall = '0; branch_flag_i = 1'b0; branch_target_i = '0;
        mem_gnt_i = 1'b0; noise = 8'h5a;

        // Reset cycle then a fully granted fetch from address 0
        applyStimulus(1'b1, 6'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t1_reset_req", 32'(mem_req_o), 32'h0);
        checkOutput("t1_reset_inst", if_inst, 32'h0);
        checkOutput("t1_reset_stallreq", 32'(stallreq_o), 32'h0);
        step(1'b1);
        checkOutput("t1_first_addr", mem_addr_o, 32'h0);
        checkOutput("t1_first_req", 32'(mem_req_o), 32'h1);
        step(1'b1); step(1'b1); step(1'b1);
        step(1'b0);
        checkOutput("t1_done_pc", if_pc, 32'h0);
        checkOutput("t1_done_inst", if_inst, 32'h00500013);
        checkOutput("t1_done_stallreq", 32'(stallreq_o), 32'h0);
        step(1'b1);
        checkOutput("t1_next_addr", mem_addr_o, 32'h4);

        // Grant withheld for three cycles in byte 2
        step(1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            checkOutput("t2_hold_addr", mem_addr_o, 32'h6);
            checkOutput("t2_hold_req", 32'(mem_req_o), 32'h1);
            checkOutput("t2_hold_stallreq", 32'(stallreq_o), 32'h1);
        end
        step(1'b1); step(1'b1); step(1'b0);

        // Redirect in byte 2 of the fetch at 8
        step(1'b1); step(1'b1);
        applyStimulus(1'b0, 6'b0, 1'b1, 32'h100, 1'b1);
        checkOutput("t3_redirect_inst", if_inst, 32'h0);
        step(1'b0);
        checkOutput("t3_target_addr", mem_addr_o, 32'h100);
        step(1'b1); step(1'b1); step(1'b1); step(1'b1);

        // Stall held in S_DONE
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 6'b000111, 1'b0, 32'h0, 1'b0);
            checkOutput("t4_stall_pc", if_pc, 32'h100);
            checkOutput("t4_stall_req", 32'(mem_req_o), 32'h0);
        end
        step(1'b0);
        step(1'b0);
        checkOutput("t4_release_addr", mem_addr_o, 32'h104);

        // Reset pulsed in byte 3 with a grant present
        step(1'b1); step(1'b1); step(1'b1);
        applyStimulus(1'b1, 6'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0);
        checkOutput("t5_after_rst_pc", if_pc, 32'h0);
        checkOutput("t5_after_rst_inst", if_inst, 32'h0);
        checkOutput("t5_after_rst_addr", mem_addr_o, 32'h0);

`ifdef IFETCH_ICACHE_EN
        // Refetch of 0 after it has been cached
        step(1'b1); step(1'b1); step(1'b1); step(1'b1);
        step(1'b0);
        applyStimulus(1'b0, 6'b0, 1'b1, 32'h0, 1'b0);
        step(1'b0);
        checkOutput("t6_hit_req", 32'(mem_req_o), 32'h0);
        step(1'b0);
        checkOutput("t6_hit_inst", if_inst, 32'h00500013);
`endif

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            st = 6'($urandom);
            st[0] = ($urandom_range(0, 9) < 4);
            case ($urandom_range(0, 3))
                0:       tgt = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
                1:       tgt = 32'($urandom_range(0, 63));
                2:       tgt = $urandom;
                default: tgt = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            endcase
            applyStimulus($urandom_range(0, 199) == 0, st, $urandom_range(0, 19) == 0,
                          tgt, $urandom_range(0, 9) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
